// File: rtl/pulse_meas_pkg.sv
// Shared types and default widths for the pulse-rate measurement path.
package pulse_meas_pkg;

    localparam int unsigned CNT_W_DEF  = 16;
    localparam int unsigned GATE_W_DEF = 24;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GATE    = 2'd1,
        CAPTURE = 2'd2
    } state_t;

endpackage

// File: rtl/gate_timer.sv
// Gate window down-counter: loads len-1, decrements to zero and holds there.
module gate_timer #(
    parameter int unsigned GATE_W = 24
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [GATE_W-1:0] i_load_val,
    input  logic              i_dec,
    output logic              o_zero_c
);

    logic [GATE_W-1:0] r_count;

    // Load has priority; decrement saturates at zero so the counter never wraps.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - GATE_W'(1);
        end
    end

    assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/pulse_gate_ctrl.sv
// Gate-window controller for the edge-detect pulse counter: enables it for a
// programmable window, samples its count and hands the sample out over valid/ready.
module pulse_gate_ctrl
    import pulse_meas_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned GATE_W = GATE_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_cont,
    input  logic [GATE_W-1:0] i_gate_len,
    input  logic [CNT_W-1:0]  i_pulse_cnt,
    output logic              o_cnt_en,
    output logic [CNT_W-1:0]  o_result,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_sat,
    output logic              o_overrun,
    output logic              o_busy
);

    state_t            r_state;
    logic              r_cnt_en;
    logic [CNT_W-1:0]  r_result;
    logic              r_valid;
    logic              r_sat;
    logic              r_overrun;
    logic              r_busy;

    state_t            w_state_nxt;
    logic              w_cnt_en_nxt;
    logic [CNT_W-1:0]  w_result_nxt;
    logic              w_valid_nxt;
    logic              w_sat_nxt;
    logic              w_overrun_nxt;
    logic              w_busy_nxt;
    logic              w_tmr_load;
    logic              w_tmr_dec;
    logic              w_tmr_zero;
    logic [GATE_W-1:0] w_load_val;

    // A zero length is run as a one-cycle window.
    assign w_load_val = (i_gate_len == '0) ? '0 : (i_gate_len - GATE_W'(1));

    gate_timer #(
        .GATE_W (GATE_W)
    ) u_gate_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_load_val),
        .i_dec      (w_tmr_dec),
        .o_zero_c   (w_tmr_zero)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_cnt_en  <= 1'b0;
            r_result  <= '0;
            r_valid   <= 1'b0;
            r_sat     <= 1'b0;
            r_overrun <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt_en  <= w_cnt_en_nxt;
            r_result  <= w_result_nxt;
            r_valid   <= w_valid_nxt;
            r_sat     <= w_sat_nxt;
            r_overrun <= w_overrun_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Next state plus result/handshake; a capture overrides an accept on the same edge.
    always_comb begin
        w_state_nxt   = r_state;
        w_result_nxt  = r_result;
        w_valid_nxt   = r_valid;
        w_sat_nxt     = r_sat;
        w_overrun_nxt = r_overrun;
        w_tmr_load    = 1'b0;
        w_tmr_dec     = 1'b0;

        if (r_valid && i_ready) begin
            w_valid_nxt = 1'b0;
        end

        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_tmr_load  = 1'b1;
                    w_state_nxt = GATE;
                end
            end
            GATE: begin
                if (w_tmr_zero) begin
                    w_state_nxt = CAPTURE;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            CAPTURE: begin
                w_result_nxt = i_pulse_cnt;
                w_valid_nxt  = 1'b1;
                w_sat_nxt    = (i_pulse_cnt == {CNT_W{1'b1}});
                if (r_valid && !i_ready) begin
                    w_overrun_nxt = 1'b1;
                end
                if (i_cont) begin
                    w_tmr_load  = 1'b1;
                    w_state_nxt = GATE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_cnt_en_nxt = (w_state_nxt == GATE);
        w_busy_nxt   = (w_state_nxt != IDLE);
    end

    assign o_cnt_en  = r_cnt_en;
    assign o_result  = r_result;
    assign o_valid   = r_valid;
    assign o_sat     = r_sat;
    assign o_overrun = r_overrun;
    assign o_busy    = r_busy;

endmodule

// File: tb/tb_pulse_gate_ctrl.sv
// Directed bench for pulse_gate_ctrl with a behavioural edge counter in the loop.
module tb_pulse_gate_ctrl;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned GATE_W = 24;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              cont;
    logic [GATE_W-1:0] gate_len;
    logic [CNT_W-1:0]  pulse_cnt;
    logic              cnt_en;
    logic [CNT_W-1:0]  result;
    logic              valid;
    logic              ready;
    logic              sat;
    logic              overrun;
    logic              busy;

    int n_tests;
    int n_fail;

    int unsigned pulse_period;
    int unsigned phase;
    int unsigned en_cycles;
    logic        pulse_evt;

    pulse_gate_ctrl #(
        .CNT_W  (CNT_W),
        .GATE_W (GATE_W)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_cont      (cont),
        .i_gate_len  (gate_len),
        .i_pulse_cnt (pulse_cnt),
        .o_cnt_en    (cnt_en),
        .o_result    (result),
        .o_valid     (valid),
        .i_ready     (ready),
        .o_sat       (sat),
        .o_overrun   (overrun),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse source: one counted edge every pulse_period cycles (0 = silent).
    assign pulse_evt = (pulse_period != 0) && (phase == 0);

    always @(posedge clk) begin
        if (pulse_period == 0 || phase + 1 >= pulse_period) phase <= 0;
        else phase <= phase + 1;
    end

    // Upstream counter model: counts while enabled, clears when enable is low.
    always @(posedge clk) begin
        if (!cnt_en) pulse_cnt <= '0;
        else if (pulse_evt) pulse_cnt <= pulse_cnt + CNT_W'(1);
    end

    always @(posedge clk) begin
        if (cnt_en) en_cycles <= en_cycles + 1;
    end

    task automatic test_reset();
        int en_seen;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        en_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cnt_en !== 1'b0) en_seen++;
        end
        n_tests++;
        if (en_seen !== 0) begin n_fail++; $display("FAIL reset_idle_en: en_high_cycles=%0d expected=0", en_seen); end
        n_tests++;
        if (result !== '0) begin n_fail++; $display("FAIL reset_result: got=%h expected=0", result); end
        n_tests++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got=%b expected=0", valid); end
        n_tests++;
        if (sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got=%b expected=0", sat); end
        n_tests++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got=%b expected=0", overrun); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got=%b expected=0", busy); end
    endtask

    task automatic test_window();
        int unsigned base;
        int k;
        base = en_cycles;
        gate_len = GATE_W'(100);
        ready = 1'b1;
        pulse_period = 10;
        start = 1'b1;
        k = 0;
        @(negedge clk); k++;
        start = 1'b0;
        while (valid !== 1'b1 && k < 300) begin
            @(negedge clk); k++;
        end
        n_tests++;
        if (k !== 102) begin n_fail++; $display("FAIL window_latency: valid_at=%0d expected=102", k); end
        n_tests++;
        if (en_cycles - base !== 100) begin n_fail++; $display("FAIL window_en_len: got=%0d expected=100", en_cycles - base); end
        n_tests++;
        if (result !== CNT_W'(10)) begin n_fail++; $display("FAIL window_result: got=%0d expected=10", result); end
        n_tests++;
        if (sat !== 1'b0) begin n_fail++; $display("FAIL window_sat: got=%b expected=0", sat); end
        @(negedge clk);
        n_tests++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL window_accept: valid=%b busy=%b expected=0 0", valid, busy);
        end
        pulse_period = 0;
    endtask

    task automatic test_len_zero();
        int unsigned base;
        int k;
        base = en_cycles;
        gate_len = '0;
        ready = 1'b0;
        start = 1'b1;
        k = 0;
        @(negedge clk); k++;
        start = 1'b0;
        while (valid !== 1'b1 && k < 20) begin
            @(negedge clk); k++;
        end
        n_tests++;
        if (k !== 3) begin n_fail++; $display("FAIL len0_latency: valid_at=%0d expected=3", k); end
        n_tests++;
        if (en_cycles - base !== 1) begin n_fail++; $display("FAIL len0_en_len: got=%0d expected=1", en_cycles - base); end
        n_tests++;
        if (result !== '0) begin n_fail++; $display("FAIL len0_result: got=%0d expected=0", result); end
        repeat (5) @(negedge clk);
        n_tests++;
        if (valid !== 1'b1 || overrun !== 1'b0) begin
            n_fail++; $display("FAIL len0_hold: valid=%b overrun=%b expected=1 0", valid, overrun);
        end
        ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL len0_accept: valid=%b expected=0", valid); end
    endtask

    task automatic test_continuous();
        int unsigned base;
        base = en_cycles;
        gate_len = GATE_W'(50);
        cont = 1'b1;
        ready = 1'b0;
        pulse_period = 5;
        start = 1'b1;
        for (int k = 1; k <= 206; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 51) begin
                n_tests++;
                if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL cont_gap_low: en=%b expected=0", cnt_en); end
            end
            if (k == 52) begin
                n_tests++;
                if (cnt_en !== 1'b1 || valid !== 1'b1 || result !== CNT_W'(10) || overrun !== 1'b0) begin
                    n_fail++;
                    $display("FAIL cont_win1: en=%b valid=%b result=%0d overrun=%b expected=1 1 10 0",
                             cnt_en, valid, result, overrun);
                end
            end
            if (k == 103) begin
                n_tests++;
                if (overrun !== 1'b1 || valid !== 1'b1 || result !== CNT_W'(10)) begin
                    n_fail++;
                    $display("FAIL cont_overrun: overrun=%b valid=%b result=%0d expected=1 1 10",
                             overrun, valid, result);
                end
            end
            if (k == 153) ready = 1'b1;
            if (k == 154) begin
                ready = 1'b0;
                n_tests++;
                if (valid !== 1'b1 || overrun !== 1'b1) begin
                    n_fail++; $display("FAIL cont_accept_on_capture: valid=%b overrun=%b expected=1 1", valid, overrun);
                end
            end
            if (k == 155) ready = 1'b1;
            if (k == 156) begin
                ready = 1'b0;
                n_tests++;
                if (valid !== 1'b0) begin n_fail++; $display("FAIL cont_accept: valid=%b expected=0", valid); end
            end
            if (k == 160) cont = 1'b0;
            if (k == 206) begin
                n_tests++;
                if (busy !== 1'b0 || valid !== 1'b1 || cnt_en !== 1'b0) begin
                    n_fail++; $display("FAIL cont_stop: busy=%b valid=%b en=%b expected=0 1 0", busy, valid, cnt_en);
                end
                n_tests++;
                if (en_cycles - base !== 200) begin
                    n_fail++; $display("FAIL cont_en_total: got=%0d expected=200", en_cycles - base);
                end
            end
        end
        pulse_period = 0;
        ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_saturate();
        int k;
        gate_len = GATE_W'(65535);
        ready = 1'b1;
        pulse_period = 1;
        start = 1'b1;
        k = 0;
        @(negedge clk); k++;
        start = 1'b0;
        while (valid !== 1'b1 && k < 70000) begin
            @(negedge clk); k++;
        end
        n_tests++;
        if (k !== 65537) begin n_fail++; $display("FAIL sat_latency: valid_at=%0d expected=65537", k); end
        n_tests++;
        if (result !== 16'hFFFF || sat !== 1'b1) begin
            n_fail++; $display("FAIL sat_value: result=%h sat=%b expected=ffff 1", result, sat);
        end
        pulse_period = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int unsigned base;
        int k;
        gate_len = GATE_W'(30);
        cont = 1'b1;
        ready = 1'b0;
        pulse_period = 3;
        start = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        n_tests++;
        if (overrun !== 1'b1 || valid !== 1'b1 || cnt_en !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pre: overrun=%b valid=%b en=%b expected=1 1 1", overrun, valid, cnt_en);
        end
        rst_n = 1'b0;
        cont = 1'b0;
        pulse_period = 0;
        @(negedge clk);
        rst_n = 1'b1;
        n_tests++;
        if (cnt_en !== 1'b0 || valid !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0 || result !== '0) begin
            n_fail++;
            $display("FAIL rstmid_post: en=%b valid=%b overrun=%b busy=%b result=%h expected=0 0 0 0 0",
                     cnt_en, valid, overrun, busy, result);
        end
        // Restart request mid-window must be ignored.
        base = en_cycles;
        gate_len = GATE_W'(40);
        ready = 1'b1;
        start = 1'b1;
        k = 0;
        @(negedge clk); k++;
        start = 1'b0;
        while (valid !== 1'b1 && k < 200) begin
            @(negedge clk); k++;
            if (k == 10) begin
                gate_len = GATE_W'(5);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        n_tests++;
        if (k !== 42 || en_cycles - base !== 40) begin
            n_fail++; $display("FAIL start_ignored: valid_at=%0d en_len=%0d expected=42 40", k, en_cycles - base);
        end
        @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        pulse_period = 0;
        phase = 0;
        en_cycles = 0;
        pulse_cnt = '0;
        rst_n = 1'b0;
        start = 1'b0;
        cont = 1'b0;
        ready = 1'b0;
        gate_len = '0;

        test_reset();
        test_window();
        test_len_zero();
        test_continuous();
        test_saturate();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
